// File: rtl/flowtbl_pkg.sv
// Shared types for the flow-table lookup: FSM states, entry record and key field layout.
package flowtbl_pkg;

  localparam int KEY_W_DEF  = 116;
  localparam int NPORT_DEF  = 4;

  // Key layout, LSB first: srcip | dstip | srcmac | ingress port
  localparam int SRCIP_LSB  = 0;
  localparam int DSTIP_LSB  = 32;
  localparam int SRCMAC_LSB = 64;
  localparam int INPORT_LSB = 112;

  typedef enum logic {
    ST_IDLE,
    ST_SEARCH
  } state_e;

  typedef struct packed {
    logic                 valid;
    logic [KEY_W_DEF-1:0] key;
    logic [KEY_W_DEF-1:0] mask;
    logic [NPORT_DEF-1:0] port;
  } flow_entry_t;

  function automatic logic [KEY_W_DEF-1:0] make_key(input logic [3:0]  inport,
                                                    input logic [47:0] srcmac,
                                                    input logic [31:0] dstip,
                                                    input logic [31:0] srcip);
    return {inport, srcmac, dstip, srcip};
  endfunction

endpackage

// File: rtl/flowtbl_mem.sv
// Flow-table storage: register array, synchronous write, asynchronous indexed read.
module flowtbl_mem
  import flowtbl_pkg::*;
#(
  parameter int NENTRY = 16,
  parameter int KEY_W  = 116,
  parameter int NPORT  = 4,
  localparam int IDX_W = $clog2(NENTRY)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_addr,
  input  logic             wr_valid,
  input  logic [KEY_W-1:0] wr_key,
  input  logic [KEY_W-1:0] wr_mask,
  input  logic [NPORT-1:0] wr_port,
  input  logic [IDX_W-1:0] rd_addr,
  output logic             rd_valid,
  output logic [KEY_W-1:0] rd_key,
  output logic [KEY_W-1:0] rd_mask,
  output logic [NPORT-1:0] rd_port
);

  logic             valid_q [NENTRY];
  logic             valid_d [NENTRY];
  logic [KEY_W-1:0] key_q   [NENTRY];
  logic [KEY_W-1:0] key_d   [NENTRY];
  logic [KEY_W-1:0] mask_q  [NENTRY];
  logic [KEY_W-1:0] mask_d  [NENTRY];
  logic [NPORT-1:0] port_q  [NENTRY];
  logic [NPORT-1:0] port_d  [NENTRY];
  logic             wr_hit;

  // Out-of-range addresses exist when NENTRY is not a power of two; drop them.
  assign wr_hit = wr_en && ({1'b0, wr_addr} < (IDX_W + 1)'(NENTRY));

  always_comb begin
    valid_d = valid_q;
    key_d   = key_q;
    mask_d  = mask_q;
    port_d  = port_q;
    if (wr_hit) begin
      valid_d[wr_addr] = wr_valid;
      key_d[wr_addr]   = wr_key;
      mask_d[wr_addr]  = wr_mask;
      port_d[wr_addr]  = wr_port;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NENTRY; i++) valid_q[i] <= 1'b0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Payload storage carries no reset; only the valid bits gate matches.
  always_ff @(posedge clk) begin
    key_q  <= key_d;
    mask_q <= mask_d;
    port_q <= port_d;
  end

  assign rd_valid = valid_q[rd_addr];
  assign rd_key   = key_q[rd_addr];
  assign rd_mask  = mask_q[rd_addr];
  assign rd_port  = port_q[rd_addr];

endmodule

// File: rtl/flowtbl_lookup.sv
// Flow-table lookup: linear priority search, one entry per cycle, lowest index wins.
module flowtbl_lookup
  import flowtbl_pkg::*;
#(
  parameter int               NENTRY    = 16,
  parameter int               NPORT     = 4,
  parameter int               KEY_W     = 116,
  parameter logic [NPORT-1:0] MISS_PORT = '1,
  localparam int              IDX_W     = $clog2(NENTRY)
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             of_lookup_req,
  input  logic [KEY_W-1:0] of_lookup_data,
  output logic             of_lookup_busy,
  output logic             of_lookup_ack,
  output logic             of_lookup_err,
  output logic             of_lookup_miss,
  output logic [NPORT-1:0] of_lookup_fwd_port,
  input  logic             tbl_wr_en,
  input  logic [IDX_W-1:0] tbl_wr_addr,
  input  logic             tbl_wr_valid,
  input  logic [KEY_W-1:0] tbl_wr_key,
  input  logic [KEY_W-1:0] tbl_wr_mask,
  input  logic [NPORT-1:0] tbl_wr_port
);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic             ack_q, ack_d;
  logic             err_q, err_d;
  logic             miss_q, miss_d;
  logic [NPORT-1:0] fwd_q, fwd_d;

  logic             rd_valid;
  logic [KEY_W-1:0] rd_key;
  logic [KEY_W-1:0] rd_mask;
  logic [NPORT-1:0] rd_port;
  logic             match;

  flowtbl_mem #(
    .NENTRY (NENTRY),
    .KEY_W  (KEY_W),
    .NPORT  (NPORT)
  ) u_mem (
    .clk      (sys_clk),
    .rst_n    (sys_rst_n),
    .wr_en    (tbl_wr_en),
    .wr_addr  (tbl_wr_addr),
    .wr_valid (tbl_wr_valid),
    .wr_key   (tbl_wr_key),
    .wr_mask  (tbl_wr_mask),
    .wr_port  (tbl_wr_port),
    .rd_addr  (idx_q),
    .rd_valid (rd_valid),
    .rd_key   (rd_key),
    .rd_mask  (rd_mask),
    .rd_port  (rd_port)
  );

  // Mask bit set means the key bit must match.
  assign match = rd_valid && (((key_q ^ rd_key) & rd_mask) == '0);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    key_d   = key_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    miss_d  = 1'b0;
    fwd_d   = fwd_q;
    unique case (state_q)
      ST_IDLE: begin
        if (of_lookup_req) begin
          key_d   = of_lookup_data;
          idx_d   = '0;
          state_d = ST_SEARCH;
        end
      end
      ST_SEARCH: begin
        if (match) begin
          ack_d   = 1'b1;
          fwd_d   = rd_port;
          err_d   = (rd_port == '0);
          state_d = ST_IDLE;
        end else if (idx_q == IDX_W'(NENTRY - 1)) begin
          ack_d   = 1'b1;
          miss_d  = 1'b1;
          fwd_d   = MISS_PORT;
          state_d = ST_IDLE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      miss_q  <= 1'b0;
      fwd_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      miss_q  <= miss_d;
      fwd_q   <= fwd_d;
    end
  end

  always_ff @(posedge sys_clk) begin
    key_q <= key_d;
  end

  assign of_lookup_busy     = (state_q == ST_SEARCH);
  assign of_lookup_ack      = ack_q;
  assign of_lookup_err      = err_q;
  assign of_lookup_miss     = miss_q;
  assign of_lookup_fwd_port = fwd_q;

endmodule

// File: tb/tb_flowtbl_lookup.sv
// Directed bench for flowtbl_lookup with a timestamp-based reference model and per-cycle compare.
module tb_flowtbl_lookup;
  import flowtbl_pkg::*;

  localparam int KW = 116;
  localparam int NP = 4;
  localparam int NE = 16;

  logic          clk = 1'b0;
  logic          sys_rst_n = 1'b0;
  logic          req = 1'b0;
  logic [KW-1:0] data = '0;
  logic          busy, ack, err, miss;
  logic [NP-1:0] fwd;
  logic          wr_en = 1'b0;
  logic [3:0]    wr_addr = '0;
  logic          wr_valid = 1'b0;
  logic [KW-1:0] wr_key = '0;
  logic [KW-1:0] wr_mask = '0;
  logic [NP-1:0] wr_port = '0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  flowtbl_lookup dut (
    .sys_clk            (clk),
    .sys_rst_n          (sys_rst_n),
    .of_lookup_req      (req),
    .of_lookup_data     (data),
    .of_lookup_busy     (busy),
    .of_lookup_ack      (ack),
    .of_lookup_err      (err),
    .of_lookup_miss     (miss),
    .of_lookup_fwd_port (fwd),
    .tbl_wr_en          (wr_en),
    .tbl_wr_addr        (wr_addr),
    .tbl_wr_valid       (wr_valid),
    .tbl_wr_key         (wr_key),
    .tbl_wr_mask        (wr_mask),
    .tbl_wr_port        (wr_port)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: entry i of a lookup accepted at edge T is judged against
  // the table as it stands just before edge T+1+i; the result appears after that edge.
  flow_entry_t   mtab [NE];
  logic          m_pend = 1'b0;
  logic [KW-1:0] m_key  = '0;
  int            m_t    = 0;
  int            m_edge = 0;
  logic          e_ack = 1'b0, e_err = 1'b0, e_miss = 1'b0, e_busy = 1'b0;
  logic [NP-1:0] e_fwd = '0;

  always @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      m_pend = 1'b0;
      e_ack = 1'b0; e_err = 1'b0; e_miss = 1'b0; e_busy = 1'b0;
      e_fwd = '0;
      for (int i = 0; i < NE; i++) mtab[i].valid = 1'b0;
    end else begin
      int idx;
      m_edge++;
      e_ack = 1'b0; e_err = 1'b0; e_miss = 1'b0;
      if (m_pend) begin
        idx = m_edge - m_t - 1;
        if (mtab[idx].valid && (((m_key ^ mtab[idx].key) & mtab[idx].mask) == '0)) begin
          e_ack = 1'b1; e_fwd = mtab[idx].port; e_err = (mtab[idx].port == '0);
          m_pend = 1'b0;
        end else if (idx == NE - 1) begin
          e_ack = 1'b1; e_miss = 1'b1; e_fwd = '1;
          m_pend = 1'b0;
        end
      end else if (req) begin
        m_pend = 1'b1; m_key = data; m_t = m_edge;
      end
      if (wr_en) mtab[wr_addr] = '{valid: wr_valid, key: wr_key, mask: wr_mask, port: wr_port};
      e_busy = m_pend;
    end
  end

  always @(negedge clk) begin
    chk("busy", 64'(busy), 64'(e_busy));
    chk("ack",  64'(ack),  64'(e_ack));
    chk("err",  64'(err),  64'(e_err));
    chk("miss", 64'(miss), 64'(e_miss));
    chk("fwd",  64'(fwd),  64'(e_fwd));
  end

  task automatic write_entry(input logic [3:0] a, input logic v, input logic [KW-1:0] k,
                             input logic [KW-1:0] m, input logic [NP-1:0] p);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_valid = v; wr_key = k; wr_mask = m; wr_port = p;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // off is the spec-style visible cycle offset from the accept edge, -1 if no ack.
  task automatic do_lookup(input logic [KW-1:0] key,
                           input int wr_n, input logic [3:0] wa, input logic [KW-1:0] wk,
                           input logic [KW-1:0] wm, input logic [NP-1:0] wp,
                           input int breq_n, input logic [KW-1:0] bkey, input int rst_at,
                           output int off, output logic [NP-1:0] o_fwd,
                           output logic o_miss, output logic o_err);
    int t;
    off = -1; o_fwd = '0; o_miss = 1'b0; o_err = 1'b0;
    @(negedge clk);
    req = 1'b1; data = key; t = cyc + 1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (ack) begin
        off = cyc + 1 - t; o_fwd = fwd; o_miss = miss; o_err = err;
        break;
      end
      if (n == 1) req = 1'b0;
      if (n == wr_n) begin
        wr_en = 1'b1; wr_addr = wa; wr_valid = 1'b1; wr_key = wk; wr_mask = wm; wr_port = wp;
      end
      if (n == wr_n + 1) wr_en = 1'b0;
      if (n == breq_n) begin req = 1'b1; data = bkey; end
      if (n == breq_n + 1) req = 1'b0;
      if (n == rst_at) begin
        #2 sys_rst_n = 1'b0;
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ack",  64'(ack),  64'd0);
        chk("rst_fwd",  64'(fwd),  64'd0);
      end
      if (n == rst_at + 1) begin req = 1'b1; data = key; end
      if (n == rst_at + 2) begin req = 1'b0; sys_rst_n = 1'b1; end
    end
    req = 1'b0;
    wr_en = 1'b0;
  endtask

  initial begin
    logic [KW-1:0] m_dst, m_src, none;
    int            off;
    logic [NP-1:0] f;
    logic          ms, er;
    int            extra;
    m_dst = make_key(4'h0, 48'h0, 32'hFFFF_FFFF, 32'h0);
    m_src = make_key(4'h0, 48'h0, 32'h0, 32'hFFFF_FFFF);
    none  = '0;

    repeat (3) @(negedge clk);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_ack",  64'(ack),  64'd0);
    chk("reset_fwd",  64'(fwd),  64'd0);
    sys_rst_n = 1'b1;

    // Empty table -> miss
    do_lookup(make_key(4'h1, 48'h0011_2233_4455, 32'h0A00_0001, 32'h0102_0304),
              -9, 4'd0, none, none, 4'h0, -9, none, -9, off, f, ms, er);
    chk("empty_off", 64'(off), 64'd17);
    chk("empty_fwd", 64'(f), 64'hF);
    chk("empty_miss", 64'(ms), 64'd1);

    // Single entry at index 3
    write_entry(4'd3, 1'b1, make_key(4'h0, 48'h0, 32'h0A00_0002, 32'h0), m_dst, 4'b0010);
    do_lookup(make_key(4'h2, 48'hAABB_CCDD_EEFF, 32'h0A00_0002, 32'h0102_0304),
              -9, 4'd0, none, none, 4'h0, -9, none, -9, off, f, ms, er);
    chk("hit3_off", 64'(off), 64'd5);
    chk("hit3_fwd", 64'(f), 64'b0010);
    chk("hit3_miss", 64'(ms), 64'd0);
    chk("hit3_err", 64'(er), 64'd0);

    // Priority between entries 1 and 5
    write_entry(4'd1, 1'b1, make_key(4'h0, 48'h0, 32'h0A00_0003, 32'h0), m_dst, 4'b0001);
    write_entry(4'd5, 1'b1, make_key(4'h0, 48'h0, 32'h0A00_0003, 32'h0), m_dst, 4'b1000);
    do_lookup(make_key(4'h3, 48'h1, 32'h0A00_0003, 32'h0102_0304),
              -9, 4'd0, none, none, 4'h0, -9, none, -9, off, f, ms, er);
    chk("prio_off", 64'(off), 64'd3);
    chk("prio_fwd", 64'(f), 64'b0001);

    // Hit with empty bitmap -> err
    write_entry(4'd0, 1'b1, make_key(4'h0, 48'h0, 32'h0, 32'hC0A8_0101), m_src, 4'b0000);
    do_lookup(make_key(4'h0, 48'h2, 32'h0A00_0009, 32'hC0A8_0101),
              -9, 4'd0, none, none, 4'h0, -9, none, -9, off, f, ms, er);
    chk("drop_off", 64'(off), 64'd2);
    chk("drop_err", 64'(er), 64'd1);
    chk("drop_fwd", 64'(f), 64'd0);

    // Write entry 6 while index 2 is compared; stray request while busy
    do_lookup(make_key(4'h0, 48'h3, 32'h0A00_0006, 32'h0102_0304),
              3, 4'd6, make_key(4'h0, 48'h0, 32'h0A00_0006, 32'h0), m_dst, 4'b0100,
              5, make_key(4'h0, 48'h0, 32'h0A00_0002, 32'h0), -9, off, f, ms, er);
    chk("inflight_off", 64'(off), 64'd8);
    chk("inflight_fwd", 64'(f), 64'b0100);
    extra = 0;
    repeat (25) begin
      @(negedge clk);
      if (ack) extra++;
    end
    chk("single_ack", 64'(extra), 64'd0);

    // Write to the entry under compare uses old contents, then hits on retry
    do_lookup(make_key(4'h0, 48'h4, 32'h0A00_0007, 32'h0102_0304),
              3, 4'd2, make_key(4'h0, 48'h0, 32'h0A00_0007, 32'h0), m_dst, 4'b0011,
              -9, none, -9, off, f, ms, er);
    chk("samecyc_off", 64'(off), 64'd17);
    chk("samecyc_miss", 64'(ms), 64'd1);
    do_lookup(make_key(4'h0, 48'h4, 32'h0A00_0007, 32'h0102_0304),
              -9, 4'd0, none, none, 4'h0, -9, none, -9, off, f, ms, er);
    chk("retry_off", 64'(off), 64'd4);
    chk("retry_fwd", 64'(f), 64'b0011);

    // Reset mid-search aborts and clears the table
    do_lookup(make_key(4'h0, 48'h5, 32'h0A00_0002, 32'h0102_0304),
              -9, 4'd0, none, none, 4'h0, -9, none, 3, off, f, ms, er);
    chk("rst_noack", 64'(off), 64'hFFFF_FFFF_FFFF_FFFF);
    do_lookup(make_key(4'h0, 48'h5, 32'h0A00_0002, 32'h0102_0304),
              -9, 4'd0, none, none, 4'h0, -9, none, -9, off, f, ms, er);
    chk("postrst_off", 64'(off), 64'd17);
    chk("postrst_miss", 64'(ms), 64'd1);
    chk("postrst_fwd", 64'(f), 64'hF);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/flowtbl_lookup.md
FLOWTBL_LOOKUP -- requirements
Module: flowtbl_lookup

Interface
REQ-001 SHALL have parameter NENTRY, default 16, number of flow-table entries (2..256).
REQ-002 SHALL have parameter NPORT, default 4, width of the forward-port bitmap.
REQ-003 SHALL have parameter KEY_W, default 116, lookup key width (ingress port 4 + srcmac 48 + dstip 32 + srcip 32).
REQ-004 SHALL have parameter MISS_PORT, default all-ones, bitmap returned on table miss.
REQ-005 SHALL have port: sys_clk  in  1  single clock; all logic on rising edge.
REQ-006 SHALL have port: sys_rst_n  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port: of_lookup_req  in  1  lookup request.
REQ-008 SHALL have port: of_lookup_data  in  KEY_W  lookup key.
REQ-009 SHALL have port: of_lookup_busy  out  1  search in progress; requests ignored.
REQ-010 SHALL have port: of_lookup_ack  out  1  one-cycle result strobe.
REQ-011 SHALL have port: of_lookup_err  out  1  with ack: hit entry has empty bitmap (drop).
REQ-012 SHALL have port: of_lookup_miss  out  1  with ack: no entry matched.
REQ-013 SHALL have port: of_lookup_fwd_port  out  NPORT  forward bitmap, valid with ack.
REQ-014 SHALL have port: tbl_wr_en  in  1  table write strobe.
REQ-015 SHALL have port: tbl_wr_addr  in  clog2(NENTRY)  entry index.
REQ-016 SHALL have ports: tbl_wr_valid (1), tbl_wr_key (KEY_W), tbl_wr_mask (KEY_W), tbl_wr_port (NPORT), all inputs, entry contents.

Function
REQ-017 SHALL implement FSM IDLE -> SEARCH -> IDLE; busy = (state == SEARCH).
REQ-018 SHALL accept a request when req=1 in IDLE at edge T; latch of_lookup_data, set index 0, enter SEARCH.
REQ-019 SHALL compare one entry per cycle: match = valid && ((key_latched ^ entry.key) & entry.mask) == 0; mask bit 1 = care.
REQ-020 SHALL give priority to lowest index; search stops at first hit.
REQ-021 SHALL, on hit at index i, assert ack for exactly one cycle, visible cycle T+2+i, with fwd_port = entry bitmap, miss=0, err = (bitmap == 0).
REQ-022 SHALL, on miss, assert ack visible cycle T+1+NENTRY with fwd_port = MISS_PORT, miss=1, err=0.
REQ-023 SHALL return to IDLE in the ack cycle; a req held high that cycle is accepted at that edge (back-to-back allowed).
REQ-024 SHALL ignore req while busy; no queuing.
REQ-025 SHALL hold fwd_port between acks; err and miss SHALL be 0 whenever ack=0.
REQ-026 SHALL apply a table write at the edge tbl_wr_en=1; write is visible to compares from the next cycle, including an in-flight search at a not-yet-scanned index.
REQ-027 SHALL let a write to the entry being compared in the same cycle not affect that compare (old contents used).
REQ-028 SHALL index wrap-free: index counter stops at NENTRY-1; tbl_wr_addr >= NENTRY SHALL be ignored.

Reset
REQ-029 SHALL on sys_rst_n=0 immediately force state IDLE, ack/err/miss/busy = 0, fwd_port = 0, all entry valid bits 0.
REQ-030 SHALL abort an in-flight search on reset with no ack; key/mask/port storage need not be reset.
REQ-031 SHALL accept no request or write while sys_rst_n=0.

Structure
REQ-032 SHALL place the entry record type (valid, key, mask, port), state enumeration and KEY_W field offsets in shared package flowtbl_pkg.
REQ-033 SHALL use one sub-module flowtbl_mem (NENTRY-entry register table, synchronous write, asynchronous indexed read).

Verification
REQ-034 SHALL test: empty table, req key dstip 10.0.0.1 -> ack at T+17 (NENTRY=16), miss=1, fwd_port=4'b1111.
REQ-035 SHALL test: entry 3 = dstip 10.0.0.2 (mask dstip only), port 4'b0010; req dstip 10.0.0.2 -> ack at T+5, fwd_port=4'b0010, miss=0, err=0.
REQ-036 SHALL test: entries 1 and 5 both match, ports 4'b0001/4'b1000 -> fwd_port=4'b0001 at T+3 (priority).
REQ-037 SHALL test: entry 0 matches with port 4'b0000 -> ack at T+2, err=1, fwd_port=0.
REQ-038 SHALL test: search in progress at index 2, write valid match to entry 6 -> hit at T+8; req asserted while busy -> ignored, single ack.
REQ-039 SHALL test: sys_rst_n low mid-search -> outputs 0 immediately, no ack, subsequent lookup misses.
